// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and sizing for the Huffman stream packer.
//   pack_state_t  : packer FSM states (RUN, FLUSH, LAST)
//   DEF_*         : default symbol, code and output-word widths
//   acc_width()   : accumulator width needed for one word plus one code
package huffman_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        LAST  = 2'd2
    } pack_state_t;

    localparam int DEF_SYM_W      = 7;
    localparam int DEF_MAX_CODE_W = 10;
    localparam int DEF_OUT_W      = 8;

    // A symbol is only accepted while fewer than OUT_W bits are held,
    // so the accumulator never needs more than OUT_W + MAX_CODE_W bits.
    function automatic int acc_width(input int out_w, input int max_code_w);
        return out_w + max_code_w;
    endfunction

endpackage

// File: rtl/huffman_table.sv
// huffman_table: combinational ASCII -> Huffman code lookup.
//   ascii        in  SYM_W       symbol (7-bit ASCII)
//   huffman_code out MAX_CODE_W  code, right-aligned
//   bit_length   out LEN_W       code length; 0 = symbol not in the code book
// The code book is sized for codes up to 10 bits and lengths up to 10.
module huffman_table
    import huffman_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int MAX_CODE_W = DEF_MAX_CODE_W,
    parameter int LEN_W      = 4
) (
    input  logic [SYM_W-1:0]      ascii,
    output logic [MAX_CODE_W-1:0] huffman_code,
    output logic [LEN_W-1:0]      bit_length
);

    logic [9:0] code10;
    logic [3:0] len4;

    always_comb begin
        code10 = '0;
        len4   = '0;
        case (ascii)
            SYM_W'(32):  begin code10 = 10'b0000000000; len4 = 4'd2;  end // ' '
            SYM_W'(101): begin code10 = 10'b0000000010; len4 = 4'd3;  end // e
            SYM_W'(116): begin code10 = 10'b0000000011; len4 = 4'd3;  end // t
            SYM_W'(97):  begin code10 = 10'b0000001000; len4 = 4'd4;  end // a
            SYM_W'(111): begin code10 = 10'b0000001001; len4 = 4'd4;  end // o
            SYM_W'(105): begin code10 = 10'b0000001010; len4 = 4'd4;  end // i
            SYM_W'(110): begin code10 = 10'b0000001011; len4 = 4'd4;  end // n
            SYM_W'(115): begin code10 = 10'b0000011000; len4 = 4'd5;  end // s
            SYM_W'(104): begin code10 = 10'b0000011001; len4 = 4'd5;  end // h
            SYM_W'(114): begin code10 = 10'b0000011010; len4 = 4'd5;  end // r
            SYM_W'(100): begin code10 = 10'b0000110110; len4 = 4'd6;  end // d
            SYM_W'(108): begin code10 = 10'b0000110111; len4 = 4'd6;  end // l
            SYM_W'(117): begin code10 = 10'b0001110000; len4 = 4'd7;  end // u
            SYM_W'(99):  begin code10 = 10'b0011100010; len4 = 4'd8;  end // c
            SYM_W'(109): begin code10 = 10'b0111000110; len4 = 4'd9;  end // m
            SYM_W'(122): begin code10 = 10'b1110001110; len4 = 4'd10; end // z
            SYM_W'(120): begin code10 = 10'b1110001111; len4 = 4'd10; end // x
            default:     begin code10 = 10'b0000000000; len4 = 4'd0;  end
        endcase
    end

    assign huffman_code = MAX_CODE_W'(code10);
    assign bit_length   = LEN_W'(len4);

endmodule

// File: rtl/huffman_stream_packer.sv
// huffman_stream_packer: streams symbols through huffman_table and packs the
// variable-length codes MSB-first into OUT_W-bit words.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     symbol handshake; in_sym symbol, in_last ends a message
//   out_valid/out_ready   word handshake; out_data packed bits (first bit at MSB)
//   out_bits              valid bits in out_data counted from the MSB
//   out_last              final word of a message
//   err                   sticky: a length-0 (unmapped) symbol was accepted
// Optional build macro HUFF_STATS_EN adds saturating counters sym_cnt and
// bit_cnt (accepted symbols / packed code bits) and the CNT_W parameter.
module huffman_stream_packer
    import huffman_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int MAX_CODE_W = DEF_MAX_CODE_W,
    parameter int LEN_W      = 4,
    parameter int OUT_W      = DEF_OUT_W
`ifdef HUFF_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SYM_W-1:0]           in_sym,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(OUT_W+1)-1:0] out_bits,
    output logic                       out_last,
    output logic                       err
`ifdef HUFF_STATS_EN
    ,
    output logic [CNT_W-1:0]           sym_cnt,
    output logic [CNT_W-1:0]           bit_cnt
`endif
);

    localparam int ACC_W  = acc_width(OUT_W, MAX_CODE_W);
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int OB_W   = $clog2(OUT_W + 1);
    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(OUT_W);

    pack_state_t           state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  err_q, err_d;

    logic [MAX_CODE_W-1:0] tbl_code, code_m;
    logic [LEN_W-1:0]      tbl_len, pad;
    logic [ACC_W-1:0]      ins;
    logic                  in_fire, pop;

    huffman_table #(
        .SYM_W      (SYM_W),
        .MAX_CODE_W (MAX_CODE_W),
        .LEN_W      (LEN_W)
    ) u_table (
        .ascii        (in_sym),
        .huffman_code (tbl_code),
        .bit_length   (tbl_len)
    );

    // Output decode uses state/fill/acc registers only: no in_* -> out_* path.
    assign in_ready  = (state_q == RUN) && (fill_q < WORD_FILL);
    assign out_valid = (state_q == LAST) || (fill_q >= WORD_FILL);
    assign out_data  = acc_q[ACC_W-1 -: OUT_W];
    assign out_last  = (state_q == LAST) || (state_q == FLUSH && fill_q == WORD_FILL);
    assign out_bits  = !out_valid        ? '0 :
                       (state_q == LAST) ? OB_W'(fill_q) : OB_W'(OUT_W);
    assign err       = err_q;

    assign in_fire = in_valid && in_ready;
    assign pop     = out_valid && out_ready;

    always_comb begin
        acc_d   = acc_q;
        fill_d  = fill_q;
        state_d = state_q;
        err_d   = err_q;

        // Drop any stray bits above the code length, then move the code's
        // MSB to the accumulator MSB and slide it down below the held bits.
        code_m = tbl_code & ~({MAX_CODE_W{1'b1}} << tbl_len);
        pad    = LEN_W'(MAX_CODE_W) - tbl_len;
        ins    = ({code_m, {OUT_W{1'b0}}} << pad) >> fill_q;

        case (state_q)
            RUN: begin
                if (in_fire) begin
                    acc_d  = acc_q | ins;
                    fill_d = fill_q + FILL_W'(tbl_len);
                    if (tbl_len == '0) err_d = 1'b1;
                    if (in_last) state_d = FLUSH;
                end else if (pop) begin
                    acc_d  = acc_q << OUT_W;
                    fill_d = fill_q - WORD_FILL;
                end
            end
            FLUSH: begin
                if (fill_q > WORD_FILL) begin
                    if (pop) begin
                        acc_d  = acc_q << OUT_W;
                        fill_d = fill_q - WORD_FILL;
                    end
                end else if (fill_q == WORD_FILL) begin
                    // Exactly one full word left: it is itself the last word.
                    if (pop) begin
                        acc_d   = '0;
                        fill_d  = '0;
                        state_d = RUN;
                    end
                end else begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (pop) begin
                    acc_d   = '0;
                    fill_d  = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

`ifdef HUFF_STATS_EN
    logic [CNT_W-1:0] sym_cnt_q, bit_cnt_q;
    logic [CNT_W:0]   bit_sum;

    assign bit_sum = {1'b0, bit_cnt_q} + (CNT_W+1)'(tbl_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (in_fire) begin
            if (~&sym_cnt_q) sym_cnt_q <= sym_cnt_q + CNT_W'(1);
            bit_cnt_q <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end
    end

    assign sym_cnt = sym_cnt_q;
    assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_huffman_stream_packer.sv
// Bench for huffman_stream_packer: directed cases plus a randomized stream,
// all words compared against a bit-queue reference model.
module tb_huffman_stream_packer;
    import huffman_pkg::*;

    localparam int SYM_W = 7;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid, in_ready, in_last;
    logic [SYM_W-1:0] in_sym;
    logic             out_valid, out_ready, out_last, err;
    logic [OUT_W-1:0] out_data;
    logic [$clog2(OUT_W+1)-1:0] out_bits;
`ifdef HUFF_STATS_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] sym_cnt, bit_cnt;
`endif

    always #5 clk = ~clk;

    huffman_stream_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_last  (out_last),
        .err       (err)
`ifdef HUFF_STATS_EN
        ,
        .sym_cnt   (sym_cnt),
        .bit_cnt   (bit_cnt)
`endif
    );

    typedef struct { logic [SYM_W-1:0] sym; bit last; } stim_t;
    typedef struct { logic [OUT_W-1:0] data; int bits; bit last; } word_t;

    stim_t stim_q[$];
    word_t exp_q[$], got_q[$];
    bit    pend[$];
    bit    m_err;
    int    m_sym, m_bits;
    int    n_chk = 0, n_err = 0;
    int    vld_pct = 100, rdy_pct = 100;
    bit    hold_pend = 0;
    logic [OUT_W-1:0] hold_data;
    int    hold_bits;
    bit    hold_last;
    string alpha = " etaoinshrdlucmzx";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference code book (code right-aligned, length 0 = unmapped).
    function automatic void ref_code(input logic [6:0] s, output int len, output int code);
        case (s)
            7'd32:   begin code = 'b00;         len = 2;  end
            7'd101:  begin code = 'b010;        len = 3;  end
            7'd116:  begin code = 'b011;        len = 3;  end
            7'd97:   begin code = 'b1000;       len = 4;  end
            7'd111:  begin code = 'b1001;       len = 4;  end
            7'd105:  begin code = 'b1010;       len = 4;  end
            7'd110:  begin code = 'b1011;       len = 4;  end
            7'd115:  begin code = 'b11000;      len = 5;  end
            7'd104:  begin code = 'b11001;      len = 5;  end
            7'd114:  begin code = 'b11010;      len = 5;  end
            7'd100:  begin code = 'b110110;     len = 6;  end
            7'd108:  begin code = 'b110111;     len = 6;  end
            7'd117:  begin code = 'b1110000;    len = 7;  end
            7'd99:   begin code = 'b11100010;   len = 8;  end
            7'd109:  begin code = 'b111000110;  len = 9;  end
            7'd122:  begin code = 'b1110001110; len = 10; end
            7'd120:  begin code = 'b1110001111; len = 10; end
            default: begin code = 0;            len = 0;  end
        endcase
    endfunction

    // Take n bits off the pending queue into one zero-padded word.
    function automatic void emit(input int n, input bit last);
        word_t w;
        w.data = '0;
        for (int i = 0; i < OUT_W; i++)
            if (i < n) w.data[OUT_W-1-i] = pend.pop_front();
        w.bits = n;
        w.last = last;
        exp_q.push_back(w);
    endfunction

    function automatic void model_accept(input logic [SYM_W-1:0] s, input bit last);
        int len, code;
        ref_code(s, len, code);
        for (int i = len - 1; i >= 0; i--) pend.push_back(code[i]);
        if (len == 0) m_err = 1;
        if (m_sym < 65535) m_sym++;
        m_bits = (m_bits + len > 65535) ? 65535 : m_bits + len;
        if (!last) begin
            while (pend.size() >= OUT_W) emit(OUT_W, 0);
        end else begin
            while (pend.size() > OUT_W) emit(OUT_W, 0);
            emit(pend.size(), 1);
        end
    endfunction

    function automatic void model_clear();
        pend.delete();
        exp_q.delete();
        got_q.delete();
        m_err  = 0;
        m_sym  = 0;
        m_bits = 0;
    endfunction

    // Monitor: observe handshakes mid-cycle, feed model, compare popped words.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            chk("ready_valid_excl", 32'(in_ready & out_valid), 0);
            if (hold_pend) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data",  32'(out_data),  32'(hold_data));
                chk("hold_bits",  32'(out_bits),  32'(hold_bits));
                chk("hold_last",  32'(out_last),  32'(hold_last));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_bits = int'(out_bits);
            hold_last = out_last;
            if (in_valid && in_ready) begin
                stim_t s;
                s = stim_q.pop_front();
                model_accept(s.sym, s.last);
            end
            if (out_valid && out_ready) begin
                word_t g, e;
                g.data = out_data;
                g.bits = int'(out_bits);
                g.last = out_last;
                got_q.push_back(g);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 32'(g.data), 32'(e.data));
                    chk("word_bits", 32'(g.bits), 32'(e.bits));
                    chk("word_last", 32'(g.last), 32'(e.last));
                end
            end
        end
    end

    // Driver: inputs change 1 time unit after the rising edge.
    initial begin
        in_valid  = 0;
        in_sym    = '0;
        in_last   = 0;
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stim_q.size() != 0 && $urandom_range(99) < vld_pct) begin
                in_valid = 1;
                in_sym   = stim_q[0].sym;
                in_last  = stim_q[0].last;
            end else begin
                in_valid = 0;
                in_sym   = SYM_W'($urandom);
                in_last  = 1'($urandom);
            end
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic push(input logic [SYM_W-1:0] s, input bit last);
        stim_t t;
        t.sym  = s;
        t.last = last;
        stim_q.push_back(t);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_no_word", 32'(out_valid), 0);
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [OUT_W-1:0] d,
                            input int bits, input bit last);
        if (got_q.size() <= idx) begin
            chk({tag, "_present"}, 0, 1);
        end else begin
            chk({tag, "_data"}, 32'(got_q[idx].data), 32'(d));
            chk({tag, "_bits"}, 32'(got_q[idx].bits), 32'(bits));
            chk({tag, "_last"}, 32'(got_q[idx].last), 32'(last));
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input bit exp_err);
        chk({tag, "_in_ready"},  32'(in_ready),  1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"},  32'(out_last),  0);
        chk({tag, "_out_bits"},  32'(out_bits),  0);
        chk({tag, "_out_data"},  32'(out_data),  0);
        chk({tag, "_err"},       32'(err),       32'(exp_err));
    endtask

    initial begin
        model_clear();

        // 1: reset state, then idle after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst", 0);
        rst_n = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("idle", 0);

        // 2: three codes crossing one word boundary
        got_q.delete();
        push(SYM_W'("e"), 0);
        push(SYM_W'(" "), 0);
        push(SYM_W'("n"), 1);
        wait_idle(200);
        chk("pack_words", 32'(got_q.size()), 2);
        chk_word("pack_w0", 0, 8'b01000101, 8, 0);
        chk_word("pack_w1", 1, 8'b10000000, 1, 1);

        // 3: backpressure with 20 symbols
        rdy_pct = 0;
        for (int i = 0; i < 20; i++)
            push(SYM_W'(alpha[$urandom_range(16)]), i == 19);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_out_valid",    32'(out_valid), 1);
        chk("bp_stalled",      32'(stim_q.size() != 0), 1);
        rdy_pct = 100;
        wait_idle(400);

        // 4: exactly 16 bits, last word is a full word
        got_q.delete();
        push(SYM_W'("n"), 0);
        push(SYM_W'("a"), 0);
        push(SYM_W'("o"), 0);
        push(SYM_W'("i"), 1);
        wait_idle(200);
        chk("exact_words", 32'(got_q.size()), 2);
        chk_word("exact_w0", 0, 8'b10111000, 8, 0);
        chk_word("exact_w1", 1, 8'b10011010, 8, 1);

        // 5: unmapped symbol as last at fill 0
        got_q.delete();
        chk("err_before", 32'(err), 0);
        push(SYM_W'("Q"), 1);
        wait_idle(200);
        chk("unmapped_words", 32'(got_q.size()), 1);
        chk_word("unmapped_w0", 0, 8'h00, 0, 1);
        chk("err_set", 32'(err), 1);

        // 6: reset mid-message with 5 bits held
        push(SYM_W'("e"), 0);
        push(SYM_W'(" "), 0);
        for (int n = 0; n < 100 && stim_q.size() != 0; n++) @(posedge clk);
        chk("mid_sent", 32'(stim_q.size()), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        @(negedge clk);
        model_clear();
        chk_idle_outputs("midrst", 0);
        @(negedge clk);
        rst_n = 1;
        push(SYM_W'("e"), 0);
        push(SYM_W'(" "), 0);
        push(SYM_W'("n"), 1);
        wait_idle(200);
        chk("after_rst_words", 32'(got_q.size()), 2);
        chk_word("after_rst_w0", 0, 8'b01000101, 8, 0);
        chk_word("after_rst_w1", 1, 8'b10000000, 1, 1);

        // Random stream
        vld_pct = 80;
        rdy_pct = 70;
        for (int i = 0; i < 10000; i++) begin
            logic [SYM_W-1:0] s;
            if ($urandom_range(7) == 0) s = SYM_W'($urandom);
            else                        s = SYM_W'(alpha[$urandom_range(16)]);
            push(s, ($urandom_range(11) == 0) || i == 9999);
        end
        wait_idle(60000);
        chk("rand_exp_empty", 32'(exp_q.size()), 0);
        chk("rand_err", 32'(err), 32'(m_err));
`ifdef HUFF_STATS_EN
        chk("sym_cnt", 32'(sym_cnt), 32'(m_sym));
        chk("bit_cnt", 32'(bit_cnt), 32'(m_bits));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
